uart_audio_sequencer: RTL and testbench

UART_AUDIO_SEQUENCER -- requirements
Module: uart_audio_sequencer

---
 rtl/uart_audio_pkg.sv | 34 +++
 rtl/sample_fifo.sv | 78 +++++++
 rtl/uart_audio_sequencer.sv | 134 +++++++++++++
 tb/tb_uart_audio_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_audio_pkg.sv
// Shared encodings and packet constants for the UART audio sequencer.
// Packet byte selection lives here so the top stays a pure control FSM.
package uart_audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned PKT_LEN  = 3;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [IDX_W-1:0]  IDX_LAST          = IDX_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10
    } seq_state_e;

    // Byte of a packet at position idx: header, sample MSB, sample LSB.
    function automatic logic [BYTE_W-1:0] pkt_byte(
        input logic [BYTE_W-1:0]   sync,
        input logic [SAMPLE_W-1:0] sample,
        input logic [IDX_W-1:0]    idx
    );
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = sync;
            2'd1:    b = sample[15:8];
            default: b = sample[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Power-of-two sample FIFO with registered full/empty/ready flags.
// The head word is a combinational read of the storage at the read pointer.
module sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_c_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ready_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             ready_q;
    logic             push_ok;
    logic             pop_ok;

    // A push on a full FIFO is only legal when a pop frees a slot at the same edge.
    assign pop_ok  = pop_i & ~empty_q;
    assign push_ok = push_i & (~full_q | pop_ok);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            ready_q <= (count_d != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_data_c_o = mem_q[rd_ptr_q];
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign ready_o     = ready_q;

endmodule

// File: rtl/uart_audio_sequencer.sv
// Buffers 16-bit PCM samples and streams each one to a byte UART as
// SYNC, MSB, LSB, handshaking every byte with Tx_Start / Tx_Done.
module uart_audio_sequencer
    import uart_audio_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [BYTE_W-1:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                CLOCK_50,
    input  logic                Reset_N,
    input  logic                Enable,
    input  logic                Sample_Valid,
    input  logic [SAMPLE_W-1:0] Sample_Data,
    output logic                Sample_Ready,
    output logic                Tx_Start,
    output logic [BYTE_W-1:0]   Tx_Data,
    input  logic                Tx_Done,
    output logic                Busy,
    output logic                Overflow,
    input  logic                Overflow_Clr
);

    seq_state_e          state_q;
    seq_state_e          state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [SAMPLE_W-1:0] hold_q;
    logic [SAMPLE_W-1:0] hold_d;
    logic                tx_start_q;
    logic                tx_start_d;
    logic [BYTE_W-1:0]   tx_data_q;
    logic [BYTE_W-1:0]   tx_data_d;
    logic                busy_q;
    logic                busy_d;
    logic                ovf_q;
    logic                ovf_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic [SAMPLE_W-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_ready;

    assign fifo_push = Sample_Valid & fifo_ready;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk         (CLOCK_50),
        .rst_n       (Reset_N),
        .push_i      (fifo_push),
        .push_data_i (Sample_Data),
        .pop_i       (fifo_pop),
        .rd_data_c_o (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .ready_o     (fifo_ready)
    );

    // Packet FSM: Tx_Start/Tx_Data are prepared on the edge that enters START.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && Enable) begin
                    fifo_pop   = 1'b1;
                    hold_d     = fifo_head;
                    idx_d      = '0;
                    tx_start_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                    state_d    = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (Tx_Done) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        tx_start_d = 1'b1;
                        tx_data_d  = pkt_byte(SYNC_BYTE, hold_q, idx_q + IDX_W'(1));
                        state_d    = START;
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Sticky overflow; a new offer against a full FIFO beats a same-cycle clear.
    assign ovf_d = (Sample_Valid & fifo_full) | (ovf_q & ~Overflow_Clr);

    always_ff @(posedge CLOCK_50 or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Sample_Ready = fifo_ready;
    assign Tx_Start     = tx_start_q;
    assign Tx_Data      = tx_data_q;
    assign Busy         = busy_q;
    assign Overflow     = ovf_q;

endmodule

// File: tb/tb_uart_audio_sequencer.sv
// Bench for uart_audio_sequencer: directed packet scenarios plus random traffic,
// all scored every cycle against a sample-queue / packet-progress reference model.
module tb_uart_audio_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  SYNC  = 8'hA5;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data  = '0;
    logic        s_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        busy;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: buffered samples and progress through the current packet.
    logic [15:0] m_q[$];
    bit          m_ovf;
    bit          m_rdy_en;
    bit          m_in_pkt;
    bit          m_start;
    int          m_sent;
    logic [15:0] m_cur;
    logic [7:0]  m_byte;

    logic [7:0]  cap[$];
    int          done_cnt   = 0;
    int          done_delay = 10;
    bit          done_auto  = 1'b1;
    bit          rand_delay = 1'b0;

    always #5 clk = ~clk;

    uart_audio_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .SYNC_BYTE  (SYNC)
    ) dut (
        .CLOCK_50     (clk),
        .Reset_N      (rst_n),
        .Enable       (en),
        .Sample_Valid (s_valid),
        .Sample_Data  (s_data),
        .Sample_Ready (s_ready),
        .Tx_Start     (tx_start),
        .Tx_Data      (tx_data),
        .Tx_Done      (tx_done),
        .Busy         (busy),
        .Overflow     (ovf),
        .Overflow_Clr (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_rdy_en = 1'b0;
        m_in_pkt = 1'b0;
        m_start  = 1'b0;
        m_sent   = 0;
        m_cur    = '0;
        m_byte   = 8'h00;
    endtask

    // One clock: advance the model from the inputs seen before the edge, score the DUT, run the Tx_Done responder.
    task automatic tick();
        logic        v, e, d, c, r;
        logic [15:0] sd;
        bit          full_prev, acc, waiting, popped;
        v = s_valid; e = en; d = tx_done; c = ovf_clr; r = rst_n; sd = s_data;
        @(posedge clk);
        #1;
        if (r) begin
            full_prev = (m_q.size() == DEPTH);
            acc       = v && m_rdy_en && !full_prev;
            m_ovf     = (v && full_prev) || (m_ovf && !c);
            waiting   = m_in_pkt && !m_start;
            m_start   = 1'b0;
            popped    = 1'b0;
            if (!m_in_pkt) begin
                if (m_q.size() > 0 && e) begin
                    m_cur    = m_q.pop_front();
                    popped   = 1'b1;
                    m_in_pkt = 1'b1;
                    m_sent   = 1;
                    m_start  = 1'b1;
                    m_byte   = SYNC;
                end
            end else if (waiting && d) begin
                if (m_sent == 3) begin
                    m_in_pkt = 1'b0;
                end else begin
                    m_sent++;
                    m_start = 1'b1;
                    m_byte  = (m_sent == 2) ? m_cur[15:8] : m_cur[7:0];
                end
            end
            if (acc) m_q.push_back(sd);
            m_rdy_en = 1'b1;
        end
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("tx_data", 32'(tx_data), 32'(m_byte));
        chk("busy", 32'(busy), 32'(m_in_pkt));
        chk("sample_ready", 32'(s_ready), 32'(m_rdy_en && (m_q.size() < DEPTH)));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        if (tx_start) cap.push_back(tx_data);
        tx_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) tx_done = 1'b1;
        end
        if (tx_start && done_auto) done_cnt = rand_delay ? int'($urandom_range(1, 6)) : done_delay;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        s_valid  = 1'b0;
        ovf_clr  = 1'b0;
        tx_done  = 1'b0;
        done_cnt = 0;
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(ovf), 0);
        chk("rst_sample_ready", 32'(s_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || m_q.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 2000), 1);
    endtask

    initial begin
        int          lat, gap, hdrs, n, base;
        logic [7:0]  exp6 [6];
        exp6 = '{8'hA5, 8'h80, 8'h00, 8'hA5, 8'h7F, 8'hFF};

        model_reset();
        do_reset();
        en = 1'b1;
        tick();
        chk("ready_after_reset", 32'(s_ready), 1);

        // Single 16'h1234 packet, Tx_Done 10 cycles after each Tx_Start.
        done_auto = 1'b1; done_delay = 10; base = cap.size();
        s_valid = 1'b1; s_data = 16'h1234;
        tick();
        s_valid = 1'b0;
        lat = 1;
        while (!tx_start && lat < 20) begin
            tick();
            lat++;
        end
        chk("first_start_latency", lat, 2);
        wait_idle("drain_1234");
        chk("pkt1234_len", cap.size() - base, 3);
        chk("pkt1234_b0", 32'(cap[base]), 32'h A5);
        chk("pkt1234_b1", 32'(cap[base + 1]), 32'h12);
        chk("pkt1234_b2", 32'(cap[base + 2]), 32'h34);

        // Fill with Tx_Done withheld, then overflow set / clear / set-wins.
        done_auto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 16'($urandom);
            tick();
        end
        s_valid = 1'b0;
        chk("ready_low_when_full", 32'(s_ready), 0);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("overflow_set", 32'(ovf), 1);
        tick();
        chk("overflow_sticky", 32'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("overflow_cleared", 32'(ovf), 0);
        s_valid = 1'b1; ovf_clr = 1'b1;
        tick();
        s_valid = 1'b0; ovf_clr = 1'b0;
        chk("overflow_set_wins", 32'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        done_auto = 1'b1; done_delay = 4; tx_done = 1'b1;
        tick();
        wait_idle("drain_full");

        // Enable dropped after the MSB start: LSB still goes, next packet waits.
        done_delay = 5; base = cap.size();
        s_valid = 1'b1; s_data = 16'($urandom);
        tick();
        s_data = 16'($urandom);
        tick();
        s_valid = 1'b0;
        n = 0;
        while (!(tx_start && m_sent == 2) && n < 100) begin
            tick();
            n++;
        end
        chk("msb_start_seen", 32'(tx_start), 1);
        en = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("lsb_sent_after_disable", cap.size() - base, 3);
        repeat (20) tick();
        chk("held_by_enable_busy", 32'(busy), 0);
        chk("held_by_enable_bytes", cap.size() - base, 3);
        en = 1'b1;
        wait_idle("drain_enable");
        chk("resumed_after_enable", cap.size() - base, 6);

        // Reset in WAIT at the MSB index drops the packet and the queued sample.
        s_valid = 1'b1; s_data = 16'($urandom);
        tick();
        s_data = 16'($urandom);
        tick();
        s_valid = 1'b0;
        n = 0;
        while (!(busy && !tx_start && m_sent == 2) && n < 100) begin
            tick();
            n++;
        end
        chk("reached_wait_msb", 32'(busy && !tx_start), 1);
        do_reset();
        base = cap.size();
        repeat (30) tick();
        chk("no_start_after_reset", cap.size() - base, 0);

        // Tx_Done pulses in IDLE and in the START cycle are ignored.
        tx_done = 1'b1;
        tick();
        repeat (3) tick();
        chk("idle_done_ignored", cap.size() - base, 0);
        done_auto = 1'b0;
        s_valid = 1'b1; s_data = 16'($urandom);
        tick();
        s_valid = 1'b0;
        n = 0;
        while (!tx_start && n < 20) begin
            tick();
            n++;
        end
        tx_done = 1'b1;
        tick();
        repeat (5) tick();
        chk("start_done_ignored_bytes", cap.size() - base, 1);
        chk("start_done_ignored_busy", 32'(busy), 1);
        done_auto = 1'b1; done_delay = 3; tx_done = 1'b1;
        tick();
        wait_idle("drain_ignored");
        chk("ignored_pkt_complete", cap.size() - base, 3);

        // Back-to-back 8000 / 7FFF with exactly one IDLE cycle between packets.
        base = cap.size();
        s_valid = 1'b1; s_data = 16'h8000;
        tick();
        s_data = 16'h7FFF;
        tick();
        s_valid = 1'b0;
        hdrs = 0; gap = 0; n = 0;
        while ((busy || m_q.size() != 0) && n < 500) begin
            if (tx_start && tx_data == SYNC) hdrs++;
            if (hdrs == 1 && !busy) gap++;
            tick();
            n++;
        end
        chk("b2b_idle_gap", gap, 1);
        chk("b2b_len", cap.size() - base, 6);
        for (int i = 0; i < 6; i++) chk("b2b_byte", 32'(cap[base + i]), 32'(exp6[i]));

        // Random traffic scored cycle by cycle against the model.
        rand_delay = 1'b1; base = cap.size();
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(0, 1) == 1);
            s_data  = 16'($urandom);
            if ($urandom_range(0, 19) == 0) en = ~en;
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        s_valid = 1'b0; ovf_clr = 1'b0; en = 1'b1;
        wait_idle("drain_random");
        chk("random_whole_packets", (cap.size() - base) % 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
